// File: rtl/ram_port_dma.sv
// ram_port_dma: stream<->RAM block-transfer engine for one RAM port; define RAM_PORT_DMA_CHECKSUM_EN for an XOR checksum output
module ram_port_dma #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12,
  parameter int LEN_WIDTH     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     dir,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]     length,
  output logic                     busy,
  output logic                     done,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  inout  logic [DATA_WIDTH-1:0]    ram_data,
  output logic                     ram_wr
`ifdef RAM_PORT_DMA_CHECKSUM_EN
  , output logic [DATA_WIDTH-1:0]  checksum
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_ISSUE, S_RD_WAIT, S_RD_OUT, S_DONE} state_t;
  state_t r_state, w_next;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic w_rd_hs, w_last, w_accept;
  // Stream strobes are gated by rst so a reset cycle never writes RAM or completes a handshake
  assign in_ready    = r_state == S_WR && !rst;
  assign out_valid   = r_state == S_RD_OUT && !rst;
  assign ram_wr      = in_ready && in_valid;
  assign w_rd_hs     = out_valid && out_ready;
  assign w_last      = r_remaining == LEN_WIDTH'(1);
  assign w_accept    = r_state == S_IDLE && start;
  assign busy        = r_state != S_IDLE && r_state != S_DONE;
  assign done        = r_state == S_DONE;
  assign out_data    = r_out_data;
  assign ram_address = r_addr;
  assign ram_data    = ram_wr ? in_data : 'z;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = !start ? S_IDLE : length == '0 ? S_DONE : dir ? S_WR : S_RD_ISSUE;
      S_WR:       w_next = ram_wr && w_last ? S_DONE : S_WR;
      S_RD_ISSUE: w_next = S_RD_WAIT;
      S_RD_WAIT:  w_next = S_RD_OUT;
      S_RD_OUT:   w_next = !w_rd_hs ? S_RD_OUT : w_last ? S_DONE : S_RD_ISSUE;
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr      <= base_addr;
        r_remaining <= length;
      end else if (ram_wr || w_rd_hs) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      if (r_state == S_RD_WAIT) r_out_data <= ram_data;
    end
  end
`ifdef RAM_PORT_DMA_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;
  assign checksum = r_checksum;
  always_ff @(posedge clk) begin
    if (rst || w_accept) r_checksum <= '0;
    else if (ram_wr) r_checksum <= r_checksum ^ in_data;
    else if (w_rd_hs) r_checksum <= r_checksum ^ r_out_data;
  end
`endif
endmodule
